slice_add_sequencer: RTL and testbench

Multi-cycle WIDTH-bit add/subtract engine built around one 4-bit CLA sum slice (sum_generator), time-multiplexed over WIDTH/4 cycles.
- Each cycle feeds one nibble pair and the registered carry into the slice.
- Collects the nibble sum and carry-out, and derives final ALU flags from the top slice's Cout/Cout_prev.
- Sits between the ALU operand/opcode decode stage and the ALU result/flag register bank; area-reduced alternative to the 16-bit parallel adder path.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/sum_generator.sv | 33 +++
 rtl/slice_add_sequencer.sv | 155 +++++++++++++++
 tb/tb_slice_add_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, slice width and saturation patterns.
// SLICE_ADD_SAT_EN selects clamping on signed overflow in slice_add_sequencer.
package alu_pkg;

    localparam int unsigned SLICE_W   = 4;
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Largest positive two's complement value of width w (zero-extended to SAT_MAX_W).
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int unsigned w);
        return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
    endfunction

    // Most negative two's complement value of width w (zero-extended to SAT_MAX_W).
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int unsigned w);
        return SAT_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sum_generator.sv
// 4-bit carry-lookahead sum slice; also exposes the carry into its MSB for overflow detection.
module sum_generator
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_c_o,
    output logic               cout_c_o,
    output logic               cout_prev_c_o
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Flat lookahead equations, no ripple between bit positions.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign sum_c_o       = p ^ c[SLICE_W-1:0];
    assign cout_c_o      = c[4];
    assign cout_prev_c_o = c[3];

endmodule

// File: rtl/slice_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract reusing one 4-bit CLA slice over WIDTH/4 cycles.
// Define SLICE_ADD_SAT_EN to clamp the result on signed overflow instead of wrapping.
module slice_add_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = $clog2(NSLICE);
    localparam int unsigned LSB_W  = IDX_W + 2;

`ifdef SLICE_ADD_SAT_EN
    localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));
`endif

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [WIDTH-1:0]   op_a_q,   op_a_d;
    logic [WIDTH-1:0]   op_b_q,   op_b_d;
    logic               cy_q,     cy_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q,  carry_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;
    logic               neg_q,    neg_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [LSB_W-1:0]   slice_lsb;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;
    logic               s_cout_prev;

    assign slice_lsb = LSB_W'(idx_q) * LSB_W'(SLICE_W);

    sum_generator u_slice (
        .a_i           (op_a_q[slice_lsb +: SLICE_W]),
        .b_i           (op_b_q[slice_lsb +: SLICE_W]),
        .cin_i         (cy_q),
        .sum_c_o       (s_sum),
        .cout_c_o      (s_cout),
        .cout_prev_c_o (s_cout_prev)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: accept in IDLE, one nibble per RUN cycle, flags on the last nibble.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    op_a_d   = a;
                    op_b_d   = op_sub ? ~b : b;
                    cy_d     = op_sub;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    neg_d    = 1'b0;
                end
            end
            RUN: begin
                result_d[slice_lsb +: SLICE_W] = s_sum;
                cy_d  = s_cout;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    carry_d = s_cout;
                    ovf_d   = s_cout ^ s_cout_prev;
`ifdef SLICE_ADD_SAT_EN
                    if (ovf_d) begin
                        result_d = op_a_q[WIDTH-1] ? SAT_N : SAT_P;
                    end
`endif
                    zero_d = (result_d == '0);
                    neg_d  = result_d[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Bench for slice_add_sequencer (WIDTH=16): directed corner cases and random operations
// checked against an integer-arithmetic reference model.
module tb_slice_add_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    int total;
    int bad;

    slice_add_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed/unsigned integer arithmetic, then wrap or clamp.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic sub,
                                  output logic [15:0] r, output logic c, output logic v,
                                  output logic z, output logic n);
        int sx, sy, exact, ux, uy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        exact = sub ? (sx - sy) : (sx + sy);
        v = (exact > 32767) || (exact < -32768);
        c = sub ? (ux >= uy) : ((ux + uy) > 65535);
        r = sub ? 16'(ux - uy) : 16'(ux + uy);
`ifdef SLICE_ADD_SAT_EN
        if (v) r = (exact > 0) ? 16'h7FFF : 16'h8000;
`endif
        z = (r == 16'h0000);
        n = r[15];
    endfunction

    // Drive one start and wait for done; lat = edges from accept to done, 0 on timeout.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic sub,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        #12;
        total++;
        if ({busy, done, result, carry, overflow, zero, negative} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, done, result, carry, overflow, zero, negative});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0000};
        logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
        logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] er;
        logic        ec, ev, ez, en;
        int lat;
        for (int i = 0; i < 5; i++) begin
            model(va[i], vb[i], vs[i], er, ec, ev, ez, en);
            run_op(va[i], vb[i], vs[i], lat);
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d expected 4", i, lat);
            end
            total++;
            if ({result, carry, overflow, zero, negative} !== {er, ec, ev, ez, en}) begin
                bad++;
                $display("FAIL dir%0d_result: got r=%h c=%b v=%b z=%b n=%b expected r=%h c=%b v=%b z=%b n=%b",
                         i, result, carry, overflow, zero, negative, er, ec, ev, ez, en);
            end
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_done_pulse: done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
        // Accept clears the previous result and raises busy.
        @(negedge clk);
        a = 16'h0101; b = 16'h0202; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || result !== 16'h0000 || done !== 1'b0) begin
            bad++;
            $display("FAIL accept_clear: busy=%b result=%h done=%b expected 1 0000 0", busy, result, done);
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_random();
        logic [15:0] x, y, er;
        logic        s, ec, ev, ez, en;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom);
            if (i % 8 == 0) y = x;
            model(x, y, s, er, ec, ev, ez, en);
            run_op(x, y, s, lat);
            total++;
            if (lat !== 4 || {result, carry, overflow, zero, negative} !== {er, ec, ev, ez, en}) begin
                bad++;
                $display("FAIL rand%0d: %h %s %h got lat=%0d r=%h c=%b v=%b z=%b n=%b expected lat=4 r=%h c=%b v=%b z=%b n=%b",
                         i, x, s ? "-" : "+", y, lat, result, carry, overflow, zero, negative,
                         er, ec, ev, ez, en);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulses, lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        pulses = 0;
        lat = 0;
        for (int i = 3; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        total++;
        if (result !== 16'h2345 || carry !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ignore_result: got r=%h c=%b v=%b expected r=2345 c=0 v=0", result, carry, overflow);
        end
        total++;
        if (pulses !== 1 || lat !== 4) begin
            bad++;
            $display("FAIL ignore_done: got pulses=%0d lat=%0d expected 1 4", pulses, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] x, y, er;
        logic        s, ec, ev, ez, en;
        int lat;
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'(i);
            model(x, y, s, er, ec, ev, ez, en);
            // Called right after done is seen, so start lands in the done cycle.
            run_op(x, y, s, lat);
            total++;
            if (lat !== 4 || {result, carry, overflow, zero, negative} !== {er, ec, ev, ez, en}) begin
                bad++;
                $display("FAIL b2b%0d: got lat=%0d r=%h c=%b v=%b expected lat=4 r=%h c=%b v=%b",
                         i, lat, result, carry, overflow, er, ec, ev);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] x, y, er;
        logic        ec, ev, ez, en;
        int lat, seen;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || result === 16'h0000) begin
            bad++;
            $display("FAIL midrun_busy: busy=%b result=%h expected busy=1 and partial result", busy, result);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, carry, overflow, zero, negative} !== 21'd0) begin
            bad++;
            $display("FAIL midrun_reset: got %h expected 0",
                     {busy, done, result, carry, overflow, zero, negative});
        end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrun_no_done: got %0d done pulses expected 0", seen);
        end
        x = 16'($urandom);
        y = 16'($urandom);
        model(x, y, 1'b1, er, ec, ev, ez, en);
        run_op(x, y, 1'b1, lat);
        total++;
        if (lat !== 4 || {result, carry, overflow, zero, negative} !== {er, ec, ev, ez, en}) begin
            bad++;
            $display("FAIL after_reset: got lat=%0d r=%h c=%b v=%b expected lat=4 r=%h c=%b v=%b",
                     lat, result, carry, overflow, er, ec, ev);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
